// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the single-port RAM arbiter between the fetch and load/store ports.
package mem_arb_pkg;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int STRB_W         = DATA_W_DEF / 8;
    localparam int STARVE_MAX_DEF = 4;

    // Counter width able to hold 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker: one-hot grant from the two requests and the fairness state.
// MEM_ARB_RR_EN selects round-robin against rr_last instead of data priority with starve counter.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int CNT_W      = cnt_width(STARVE_MAX)
) (
    input  logic             inst_req_i,
    input  logic             data_req_i,
`ifdef MEM_ARB_RR_EN
    input  owner_e           rr_last_i,
`else
    input  logic [CNT_W-1:0] starve_cnt_i,
`endif
    output logic             gnt_inst_o,
    output logic             gnt_data_o
);

    logic inst_wins;

`ifdef MEM_ARB_RR_EN
    assign inst_wins = (rr_last_i == OWN_DATA);
`else
    assign inst_wins = (starve_cnt_i == CNT_W'(STARVE_MAX));
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt_inst_o = 1'b0;
        gnt_data_o = 1'b0;
        if (inst_req_i && data_req_i) begin
            gnt_inst_o = inst_wins;
            gnt_data_o = !inst_wins;
        end else begin
            gnt_inst_o = inst_req_i;
            gnt_data_o = data_req_i;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port RAM between instruction-fetch and data ports, one access/cycle.
// Define MEM_ARB_RR_EN for round-robin conflicts; default is data priority with starvation guard.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                ram_en,
    output logic [DATA_W/8-1:0] ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);

    localparam int CNT_W = cnt_width(STARVE_MAX);

    logic   pick_inst, pick_data;
    logic   gnt_inst, gnt_data, gnt_any;
    logic   resp_vld_q, resp_vld_d;
    owner_e resp_own_q, resp_own_d;

`ifdef MEM_ARB_RR_EN
    owner_e rr_last_q, rr_last_d;
`else
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
`endif

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_pick (
        .inst_req_i   (inst_req),
        .data_req_i   (data_req),
`ifdef MEM_ARB_RR_EN
        .rr_last_i    (rr_last_q),
`else
        .starve_cnt_i (starve_cnt_q),
`endif
        .gnt_inst_o   (pick_inst),
        .gnt_data_o   (pick_data)
    );

    // No access may start while reset is held, even though the picker is purely combinational.
    assign gnt_inst = pick_inst && rst;
    assign gnt_data = pick_data && rst;
    assign gnt_any  = gnt_inst || gnt_data;

    assign inst_addr_ok = gnt_inst;
    assign data_addr_ok = gnt_data;

    assign ram_en    = gnt_any;
    assign ram_we    = gnt_data ? data_wstrb : '0;
    assign ram_addr  = gnt_data ? data_addr : inst_addr;
    assign ram_wdata = data_wdata;

    assign resp_vld_d = gnt_any;
    assign resp_own_d = gnt_data ? OWN_DATA : OWN_INST;

    assign inst_data_ok = resp_vld_q && (resp_own_q == OWN_INST);
    assign data_data_ok = resp_vld_q && (resp_own_q == OWN_DATA);
    assign inst_rdata   = ram_rdata;
    assign data_rdata   = ram_rdata;

`ifdef MEM_ARB_RR_EN
    assign rr_last_d = gnt_any ? resp_own_d : rr_last_q;
`else
    always_comb begin
        starve_cnt_d = '0;
        if (inst_req && !gnt_inst) begin
            starve_cnt_d = (starve_cnt_q == CNT_W'(STARVE_MAX)) ? starve_cnt_q
                                                                : starve_cnt_q + 1'b1;
        end
    end
`endif

    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_vld_q <= 1'b0;
            resp_own_q <= OWN_INST;
`ifdef MEM_ARB_RR_EN
            rr_last_q  <= OWN_INST;
`else
            starve_cnt_q <= '0;
`endif
        end else begin
            resp_vld_q <= resp_vld_d;
            resp_own_q <= resp_own_d;
`ifdef MEM_ARB_RR_EN
            rr_last_q  <= rr_last_d;
`else
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: RAM model, per-cycle behavioural model, directed tests.
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr, ram_wdata;
    logic [31:0] ram_rdata = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_str(input string name, input string got, input string exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, got, exp);
        end
    endtask

    // ---------------- RAM model (read-first, byte writes) ----------------
    logic [31:0] mem [1024];
    bit          loaded = 1'b0;

    function automatic logic [31:0] preset(input int idx);
        if (idx == 32'h40 >> 2)  return 32'hFFFF_FFFF;
        if (idx == 32'h100 >> 2) return 32'hDEAD_BEEF;
        return 32'hA500_0000 | idx;
    endfunction

    always @(posedge clk) begin
        if (!loaded) begin
            loaded <= 1'b1;
            for (int i = 0; i < 1024; i++) mem[i] <= preset(i);
        end else if (ram_en) begin
            ram_rdata <= mem[ram_addr[11:2]];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    // ---------------- behavioural model + compare ----------------
    typedef struct {
        bit          vld;
        bit          is_data;
        bit          is_read;
        logic [31:0] rdata;
    } pend_t;

    pend_t pend      = '{0, 0, 0, 32'h0};
    int    inst_wait = 0;      // consecutive cycles fetch asked and was refused
    bit    last_data = 1'b0;   // last granted access belonged to data port
    bit    log_en    = 1'b0;
    string glog      = "";
    int    iok_cnt   = 0;
    int    dok_cnt   = 0;

    always @(negedge clk) begin
        bit          ei, ed;
        logic [31:0] a;
        pend_t       nxt;
        if (log_en) begin
            if (inst_addr_ok) glog = {glog, "I"};
            if (data_addr_ok) glog = {glog, "D"};
            if (inst_data_ok) iok_cnt++;
            if (data_data_ok) dok_cnt++;
        end
        if (!rst) begin
            check("rst_inst_addr_ok", inst_addr_ok, 0);
            check("rst_data_addr_ok", data_addr_ok, 0);
            check("rst_ram_en",       ram_en, 0);
            check("rst_inst_data_ok", inst_data_ok, 0);
            check("rst_data_data_ok", data_data_ok, 0);
            pend      = '{0, 0, 0, 32'h0};
            inst_wait = 0;
            last_data = 1'b0;
        end else begin
            if (inst_req && data_req) begin
`ifdef MEM_ARB_RR_EN
                ei = last_data;
`else
                ei = (inst_wait >= STARVE_MAX);
`endif
                ed = !ei;
            end else begin
                ei = inst_req;
                ed = data_req;
            end
            check("inst_addr_ok", inst_addr_ok, ei);
            check("data_addr_ok", data_addr_ok, ed);
            check("ram_en",       ram_en, ei | ed);
            a = ed ? data_addr : inst_addr;
            if (ei | ed) begin
                check("ram_addr", ram_addr, a);
                check("ram_we",   ram_we, ed ? data_wstrb : 4'h0);
                if (ed && data_wstrb != 0) check("ram_wdata", ram_wdata, data_wdata);
            end
            check("inst_data_ok", inst_data_ok, pend.vld && !pend.is_data);
            check("data_data_ok", data_data_ok, pend.vld && pend.is_data);
            if (pend.vld && pend.is_read) begin
                if (pend.is_data) check("data_rdata", data_rdata, pend.rdata);
                else              check("inst_rdata", inst_rdata, pend.rdata);
            end
            nxt.vld     = ei | ed;
            nxt.is_data = ed;
            nxt.is_read = ei || (data_wstrb == 4'h0);
            nxt.rdata   = mem[a[11:2]];
            pend        = nxt;
            inst_wait   = (inst_req && !ei) ? inst_wait + 1 : 0;
            if (ei | ed) last_data = ed;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req   = 1'b0;
        inst_addr  = 32'h0;
        data_req   = 1'b0;
        data_wstrb = 4'h0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
    endtask

    task automatic do_reset();
        step();
        idle_inputs();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic start_log();
        glog    = "";
        iok_cnt = 0;
        dok_cnt = 0;
        log_en  = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        step();
        inst_req = 1'b1;
        #1;
        check("reset_blocks_grant", inst_addr_ok, 0);
        check("reset_blocks_ram",   ram_en, 0);
        step();
        idle_inputs();
        rst = 1'b1;
        step();

        // Test 1: lone fetch of 0x100
        inst_req  = 1'b1;
        inst_addr = 32'h100;
        #1;
        check("t1_addr_ok_c0", inst_addr_ok, 1);
        step();
        inst_req = 1'b0;
        #1;
        check("t1_data_ok_c1", inst_data_ok, 1);
        check("t1_rdata",      inst_rdata, 32'hDEAD_BEEF);
        step();
        check("t1_data_ok_c2", inst_data_ok, 0);

        // Test 2: partial store then load of 0x40
        data_req   = 1'b1;
        data_wstrb = 4'b0011;
        data_addr  = 32'h40;
        data_wdata = 32'h1234_5678;
        #1;
        check("t2_store_addr_ok", data_addr_ok, 1);
        check("t2_store_we",      ram_we, 4'b0011);
        step();
        check("t2_store_data_ok", data_data_ok, 1);
        data_wstrb = 4'h0;
        data_wdata = 32'h0;
        step();
        check("t2_load_data_ok", data_data_ok, 1);
        check("t2_load_rdata",   data_rdata, 32'hFFFF_5678);
        idle_inputs();
        step();

        // Test 3/4: both ports held, conflict resolution pattern
        do_reset();
        step();
        start_log();
        inst_req  = 1'b1;
        inst_addr = 32'h200;
        data_req  = 1'b1;
        data_addr = 32'h300;
        repeat (10) step();
        idle_inputs();
        step();
        log_en = 1'b0;
`ifdef MEM_ARB_RR_EN
        check_str("t4_grant_seq", glog, "DIDIDIDIDI");
        check("t4_inst_ok_cnt", iok_cnt, 5);
        check("t4_data_ok_cnt", dok_cnt, 5);
`else
        check_str("t3_grant_seq", glog, "DDDDIDDDDI");
        check("t3_inst_ok_cnt", iok_cnt, 2);
        check("t3_data_ok_cnt", dok_cnt, 8);
`endif

        // Test 5: back-to-back fetches
        start_log();
        inst_req  = 1'b1;
        inst_addr = 32'h0;
        step();
        inst_addr = 32'h4;
        step();
        inst_addr = 32'h8;
        step();
        inst_req = 1'b0;
        step();
        log_en = 1'b0;
        check_str("t5_grant_seq", glog, "III");
        check("t5_inst_ok_cnt", iok_cnt, 3);

        // Test 6: reset right after a data grant discards the response
        data_req  = 1'b1;
        data_addr = 32'h40;
        step();
        data_req = 1'b0;
        rst      = 1'b0;
        start_log();
        #1;
        check("t6_data_ok_killed", data_data_ok, 0);
        inst_req = 1'b1;
        #1;
        check("t6_ram_en_in_rst", ram_en, 0);
        step();
        step();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        log_en = 1'b0;
        check("t6_data_ok_cnt", dok_cnt, 0);
        check("t6_inst_ok_cnt", iok_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
